// File: rtl/sadd_pkg.sv
// Shared saturating-add constants and clamp helper, common to the scheduler
// and the standalone adder.
package sadd_pkg;

    localparam int DATA_WIDTH_DEFAULT = 32;

    localparam logic signed [DATA_WIDTH_DEFAULT:0]   POS_SAT_LIMIT_DEFAULT = 33'sd2147483647;
    localparam logic signed [DATA_WIDTH_DEFAULT:0]   NEG_SAT_LIMIT_DEFAULT = -33'sd2147483647;
    localparam logic signed [DATA_WIDTH_DEFAULT-1:0] POS_SAT_VALUE_DEFAULT = 32'sd2147483647;
    localparam logic signed [DATA_WIDTH_DEFAULT-1:0] NEG_SAT_VALUE_DEFAULT = -32'sd2147483647;

    typedef struct packed {
        logic [DATA_WIDTH_DEFAULT-1:0] value;
        logic                          clamped;
    } sat_result_t;

    // Symmetric clamp: -2^31 never leaves, so downstream negation is always safe.
    function automatic sat_result_t sat_clamp(input logic signed [DATA_WIDTH_DEFAULT:0] sum);
        sat_result_t r;
        r.clamped = 1'b1;
        if (sum > POS_SAT_LIMIT_DEFAULT)
            r.value = POS_SAT_VALUE_DEFAULT;
        else if (sum < NEG_SAT_LIMIT_DEFAULT)
            r.value = NEG_SAT_VALUE_DEFAULT;
        else begin
            r.value   = sum[DATA_WIDTH_DEFAULT-1:0];
            r.clamped = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_sadd_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at a registered
// pointer; pointer moves past the winner on every grant.
module rr_arbiter #(
    parameter int NCH       = 4,
    parameter int CID_WIDTH = 2
) (
    input  logic                 a_clk,
    input  logic                 a_rst,
    input  logic [NCH-1:0]       req,
    input  logic                 en,
    output logic [NCH-1:0]       grant,
    output logic [CID_WIDTH-1:0] gid,
    output logic                 gvalid
);

    logic [CID_WIDTH-1:0] ptr;

    function automatic int wrap(input int v);
        return (v >= NCH) ? v - NCH : v;
    endfunction

    // Scan farthest-first so the nearest requester after ptr overwrites last.
    always_comb begin
        grant  = '0;
        gid    = '0;
        gvalid = 1'b0;
        if (en) begin
            for (int k = NCH - 1; k >= 0; k--) begin
                if (req[wrap(int'(ptr) + k)]) begin
                    grant                        = '0;
                    grant[wrap(int'(ptr) + k)]   = 1'b1;
                    gid                          = CID_WIDTH'(wrap(int'(ptr) + k));
                    gvalid                       = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge a_clk) begin
        if (a_rst)
            ptr <= '0;
        else if (gvalid)
            ptr <= (int'(gid) == NCH - 1) ? '0 : gid + CID_WIDTH'(1);
    end

endmodule

// File: rtl/axis_sadd_sched.sv
// Time-shares one 2-stage saturating adder among NCH AXI-Stream requesters,
// tagging each result with its channel id and tracking saturation events.
module axis_sadd_sched
    import sadd_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int CID_WIDTH  = 2,
    parameter logic signed [DATA_WIDTH:0]   POS_SATURATION_LIMIT = POS_SAT_LIMIT_DEFAULT,
    parameter logic signed [DATA_WIDTH:0]   NEG_SATURATION_LIMIT = NEG_SAT_LIMIT_DEFAULT,
    parameter logic signed [DATA_WIDTH-1:0] POS_SATURATION_VALUE = POS_SAT_VALUE_DEFAULT,
    parameter logic signed [DATA_WIDTH-1:0] NEG_SATURATION_VALUE = NEG_SAT_VALUE_DEFAULT
) (
    input  logic                      a_clk,
    input  logic                      a_rst,
    input  logic [NCH*2*DATA_WIDTH-1:0] S_AXIS_REQ_tdata,
    input  logic [NCH-1:0]            S_AXIS_REQ_tvalid,
    output logic [NCH-1:0]            S_AXIS_REQ_tready,
    output logic [DATA_WIDTH-1:0]     M_AXIS_SUM_tdata,
    output logic [CID_WIDTH-1:0]      M_AXIS_SUM_tuser,
    output logic                      M_AXIS_SUM_tvalid,
    input  logic                      M_AXIS_SUM_tready,
    output logic [NCH-1:0]            sat_flags,
    input  logic                      sat_clear,
    output logic [15:0]               sat_count
);

    logic                         adv;
    logic [NCH-1:0]               grant;
    logic [CID_WIDTH-1:0]         gid;
    logic                         gvalid;
    logic [DATA_WIDTH-1:0]        a_sel;
    logic [DATA_WIDTH-1:0]        b_sel;
    logic signed [DATA_WIDTH:0]   s1_sum;
    logic [CID_WIDTH-1:0]         s1_id;
    logic                         s1_v;
    logic                         pos_sat;
    logic                         neg_sat;
    logic                         sat_event;

    assign adv = !M_AXIS_SUM_tvalid || M_AXIS_SUM_tready;

    rr_arbiter #(
        .NCH       (NCH),
        .CID_WIDTH (CID_WIDTH)
    ) u_arb (
        .a_clk  (a_clk),
        .a_rst  (a_rst),
        .req    (S_AXIS_REQ_tvalid),
        .en     (adv && !a_rst),
        .grant  (grant),
        .gid    (gid),
        .gvalid (gvalid)
    );

    assign S_AXIS_REQ_tready = grant;

    always_comb begin
        a_sel = S_AXIS_REQ_tdata[int'(gid)*2*DATA_WIDTH +: DATA_WIDTH];
        b_sel = S_AXIS_REQ_tdata[int'(gid)*2*DATA_WIDTH + DATA_WIDTH +: DATA_WIDTH];
    end

    assign pos_sat   = s1_sum > POS_SATURATION_LIMIT;
    assign neg_sat   = s1_sum < NEG_SATURATION_LIMIT;
    assign sat_event = adv && s1_v && (pos_sat || neg_sat);

    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            s1_sum            <= '0;
            s1_id             <= '0;
            s1_v              <= 1'b0;
            M_AXIS_SUM_tvalid <= 1'b0;
            M_AXIS_SUM_tdata  <= '0;
            M_AXIS_SUM_tuser  <= '0;
        end else if (adv) begin
            s1_sum            <= {a_sel[DATA_WIDTH-1], a_sel} + {b_sel[DATA_WIDTH-1], b_sel};
            s1_id             <= gid;
            s1_v              <= gvalid;
            M_AXIS_SUM_tvalid <= s1_v;
            M_AXIS_SUM_tuser  <= s1_id;
            if (pos_sat)
                M_AXIS_SUM_tdata <= POS_SATURATION_VALUE;
            else if (neg_sat)
                M_AXIS_SUM_tdata <= NEG_SATURATION_VALUE;
            else
                M_AXIS_SUM_tdata <= s1_sum[DATA_WIDTH-1:0];
        end
    end

    // A fresh event wins over a same-cycle clear.
    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            sat_flags <= '0;
            sat_count <= '0;
        end else begin
            if (sat_clear)
                sat_flags <= '0;
            if (sat_event) begin
                sat_flags[s1_id] <= 1'b1;
                if (sat_count != 16'hFFFF)
                    sat_count <= sat_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_axis_sadd_sched.sv
// Directed bench for axis_sadd_sched: reset, sums, clamps, flags, round-robin
// order, back-pressure and reset with results in flight.
module tb_axis_sadd_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] req_data;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [31:0]  sum_data;
    logic [1:0]   sum_user;
    logic         sum_valid;
    logic         sum_ready;
    logic [3:0]   flags;
    logic         clr;
    logic [15:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    axis_sadd_sched dut (
        .a_clk             (clk),
        .a_rst             (rst),
        .S_AXIS_REQ_tdata  (req_data),
        .S_AXIS_REQ_tvalid (req_valid),
        .S_AXIS_REQ_tready (req_ready),
        .M_AXIS_SUM_tdata  (sum_data),
        .M_AXIS_SUM_tuser  (sum_user),
        .M_AXIS_SUM_tvalid (sum_valid),
        .M_AXIS_SUM_tready (sum_ready),
        .sat_flags         (flags),
        .sat_clear         (clr),
        .sat_count         (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [31:0] a, input logic [31:0] b);
        req_data[ch*64 +: 32]      = a;
        req_data[ch*64 + 32 +: 32] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'hF; sum_ready = 1'b1; clr = 1'b0; req_data = '0;
        step();
        step();
        n_tests++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_tready got=%h exp=0", req_ready); end
        n_tests++; if (sum_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got=%b exp=0", sum_valid); end
        n_tests++; if (sum_data !== 32'h0 || sum_user !== 2'd0) begin n_fail++; $display("FAIL reset_out got=%h/%0d exp=0/0", sum_data, sum_user); end
        n_tests++; if (flags !== 4'h0 || count !== 16'd0) begin n_fail++; $display("FAIL reset_sat got=%h/%0d exp=0/0", flags, count); end
        req_valid = 4'h0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        set_ch(2, 32'd100, 32'hFFFF_FFE2);
        req_valid = 4'b0100;
        #1;
        n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant got=%b exp=0100", req_ready); end
        step();
        req_valid = 4'h0;
        n_tests++; if (sum_valid !== 1'b0) begin n_fail++; $display("FAIL single_early got=%b exp=0", sum_valid); end
        step();
        n_tests++; if (sum_valid !== 1'b1 || sum_data !== 32'd70 || sum_user !== 2'd2)
            begin n_fail++; $display("FAIL single_out got=%b/%h/%0d exp=1/00000046/2", sum_valid, sum_data, sum_user); end
        n_tests++; if (flags !== 4'h0 || count !== 16'd0) begin n_fail++; $display("FAIL single_sat got=%h/%0d exp=0/0", flags, count); end
        step();
        n_tests++; if (sum_valid !== 1'b0) begin n_fail++; $display("FAIL single_once got=%b exp=0", sum_valid); end
    endtask

    task automatic test_pos_sat();
        set_ch(0, 32'h7FFF_FFF0, 32'h0000_0020);
        req_valid = 4'b0001;
        step();
        req_valid = 4'h0;
        step();
        n_tests++; if (sum_data !== 32'h7FFF_FFFF || sum_user !== 2'd0) begin n_fail++; $display("FAIL pos_sat_data got=%h/%0d exp=7fffffff/0", sum_data, sum_user); end
        n_tests++; if (flags !== 4'b0001 || count !== 16'd1) begin n_fail++; $display("FAIL pos_sat_flags got=%b/%0d exp=0001/1", flags, count); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_tests++; if (flags !== 4'h0 || count !== 16'd1) begin n_fail++; $display("FAIL sat_clear got=%b/%0d exp=0000/1", flags, count); end
        // Upper boundary: exactly the positive limit passes unclamped.
        set_ch(3, 32'h7FFF_FFFF, 32'h0);
        req_valid = 4'b1000;
        step();
        req_valid = 4'h0;
        step();
        n_tests++; if (sum_data !== 32'h7FFF_FFFF || flags !== 4'h0 || count !== 16'd1)
            begin n_fail++; $display("FAIL pos_edge got=%h/%b/%0d exp=7fffffff/0000/1", sum_data, flags, count); end
    endtask

    task automatic test_neg_sat();
        set_ch(1, 32'h8000_0000, 32'hFFFF_FFFF);
        req_valid = 4'b0010;
        step();
        req_valid = 4'h0;
        step();
        n_tests++; if (sum_data !== 32'h8000_0001 || sum_user !== 2'd1) begin n_fail++; $display("FAIL neg_sat_data got=%h/%0d exp=80000001/1", sum_data, sum_user); end
        n_tests++; if (flags !== 4'b0010 || count !== 16'd2) begin n_fail++; $display("FAIL neg_sat_flags got=%b/%0d exp=0010/2", flags, count); end
        set_ch(1, 32'h8000_0000, 32'h0);
        req_valid = 4'b0010;
        step();
        req_valid = 4'h0;
        step();
        n_tests++; if (sum_data !== 32'h8000_0001 || count !== 16'd3) begin n_fail++; $display("FAIL neg_min_in got=%h/%0d exp=80000001/3", sum_data, count); end
        // Lower boundary: exactly the negative limit passes unclamped.
        set_ch(1, 32'h8000_0001, 32'h0);
        req_valid = 4'b0010;
        step();
        req_valid = 4'h0;
        step();
        n_tests++; if (sum_data !== 32'h8000_0001 || count !== 16'd3) begin n_fail++; $display("FAIL neg_edge got=%h/%0d exp=80000001/3", sum_data, count); end
        // Clear and a new event in the same cycle: the new flag survives.
        set_ch(2, 32'h8000_0000, 32'h8000_0000);
        req_valid = 4'b0100;
        step();
        req_valid = 4'h0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_tests++; if (flags !== 4'b0100 || count !== 16'd4) begin n_fail++; $display("FAIL clr_vs_set got=%b/%0d exp=0100/4", flags, count); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int ch = 0; ch < 4; ch++) set_ch(ch, 32'(ch * 10), 32'd1);
        req_valid = 4'hF;
        for (int c = 0; c < 10; c++) begin
            if (c == 8) req_valid = 4'h0;
            #0;
            if (c < 8) begin
                n_tests++; if (req_ready !== 4'(1 << (c % 4))) begin n_fail++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, req_ready, 4'(1 << (c % 4))); end
            end
            if (c >= 2) begin
                n_tests++;
                if (sum_valid !== 1'b1 || sum_user !== 2'((c - 2) % 4) || sum_data !== 32'(((c - 2) % 4) * 10 + 1))
                    begin n_fail++; $display("FAIL rr_out c=%0d got=%b/%0d/%0d exp=1/%0d/%0d", c, sum_valid, sum_user, sum_data, (c - 2) % 4, ((c - 2) % 4) * 10 + 1); end
            end
            step();
        end
    endtask

    task automatic test_back_pressure();
        // Pointer sits at 0 after the 8 round-robin grants.
        req_valid = 4'hF;
        sum_ready = 1'b1;
        step();
        step();
        sum_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #0;
            n_tests++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL stall_tready s=%0d got=%b exp=0000", s, req_ready); end
            n_tests++; if (sum_valid !== 1'b1 || sum_user !== 2'd0 || sum_data !== 32'd1)
                begin n_fail++; $display("FAIL stall_hold s=%0d got=%b/%0d/%0d exp=1/0/1", s, sum_valid, sum_user, sum_data); end
            step();
        end
        sum_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #0;
            n_tests++; if (req_ready !== 4'(1 << ((j + 2) % 4))) begin n_fail++; $display("FAIL resume_grant j=%0d got=%b exp=%b", j, req_ready, 4'(1 << ((j + 2) % 4))); end
            n_tests++; if (sum_valid !== 1'b1 || sum_user !== 2'(j) || sum_data !== 32'(j * 10 + 1))
                begin n_fail++; $display("FAIL resume_out j=%0d got=%b/%0d/%0d exp=1/%0d/%0d", j, sum_valid, sum_user, sum_data, j, j * 10 + 1); end
            step();
        end
        req_valid = 4'h0;
        step();
        step();
    endtask

    task automatic test_reset_inflight();
        for (int ch = 0; ch < 4; ch++) set_ch(ch, 32'h7FFF_FFFF, 32'd1);
        req_valid = 4'hF;
        step();
        step();
        n_tests++; if (sum_valid !== 1'b1 || count !== 16'd1) begin n_fail++; $display("FAIL inflight_pre got=%b/%0d exp=1/1", sum_valid, count); end
        rst = 1'b1;
        #1;
        n_tests++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL inflight_rst_tready got=%b exp=0000", req_ready); end
        step();
        n_tests++; if (sum_valid !== 1'b0 || count !== 16'd0 || flags !== 4'h0)
            begin n_fail++; $display("FAIL inflight_rst got=%b/%0d/%b exp=0/0/0000", sum_valid, count, flags); end
        rst = 1'b0;
        req_valid = 4'b1010;
        #1;
        n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL post_rst_grant got=%b exp=0010", req_ready); end
        req_valid = 4'hF;
        #1;
        n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL post_rst_ch0 got=%b exp=0001", req_ready); end
        step();
        req_valid = 4'h0;
        n_tests++; if (sum_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_flush got=%b exp=0", sum_valid); end
        step();
        n_tests++; if (sum_valid !== 1'b1 || sum_user !== 2'd0 || sum_data !== 32'h7FFF_FFFF)
            begin n_fail++; $display("FAIL post_rst_out got=%b/%0d/%h exp=1/0/7fffffff", sum_valid, sum_user, sum_data); end
        step();
        n_tests++; if (sum_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_dup got=%b exp=0", sum_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_pos_sat();
        test_neg_sat();
        test_round_robin();
        test_back_pressure();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
